// File: rtl/pulse_channel_pkg.sv
// Shared encodings for the pulse channel: FSM state codes and duty thresholds.
package pulse_channel_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DECAY = 2'd2;

  localparam logic [1:0] DUTY_12 = 2'd0;
  localparam logic [1:0] DUTY_25 = 2'd1;
  localparam logic [1:0] DUTY_50 = 2'd2;
  localparam logic [1:0] DUTY_75 = 2'd3;

  // Waveform is high while the top three phase bits are below this value.
  function automatic logic [2:0] duty_threshold(input logic [1:0] duty);
    logic [2:0] thr;
    case (duty)
      DUTY_12: thr = 3'd1;
      DUTY_25: thr = 3'd2;
      DUTY_50: thr = 3'd4;
      default: thr = 3'd6;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/pulse_env_unit.sv
// Level register, envelope divider and length counter, clocked by the frame tick.
module pulse_env_unit #(
  parameter int VOL_W = 4,
  parameter int LEN_W = 8,
  parameter int ENV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             tick,
  input  logic             active,
  input  logic             decay,
  input  logic [VOL_W-1:0] volume,
  input  logic [LEN_W-1:0] length,
  input  logic [ENV_W-1:0] period,
  output logic [VOL_W-1:0] level,
  output logic             expire
);

  logic [LEN_W-1:0] len;
  logic [ENV_W-1:0] div;
  logic [ENV_W-1:0] period_reg;
  logic             step;
  logic             env_step;

  // A trigger in the same cycle swallows the tick.
  assign step     = tick && !trigger && active;
  assign env_step = step && decay && (div == '0);
  assign expire   = step && ((len == LEN_W'(1)) || (env_step && level == VOL_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      level      <= '0;
      len        <= '0;
      div        <= '0;
      period_reg <= '0;
    end else if (trigger) begin
      level      <= volume;
      len        <= length;
      div        <= period;
      period_reg <= period;
    end else if (step) begin
      if (len != '0) len <= len - LEN_W'(1);
      if (decay) begin
        if (div == '0) begin
          div   <= period_reg;
          level <= level - VOL_W'(1);
        end else begin
          div <= div - ENV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pulse_channel_gen.sv
// Pulse-wave channel: phase accumulator with duty select, gated by envelope/length FSM.
module pulse_channel_gen
  import pulse_channel_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 9,
  parameter int VOL_W   = 4,
  parameter int LEN_W   = 8,
  parameter int ENV_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [PHASE_W-1:0] i_phase_delta,
  input  logic               i_phase_delta_valid,
  input  logic               i_trigger,
  input  logic [1:0]         i_duty,
  input  logic [VOL_W-1:0]   i_volume,
  input  logic               i_env_decay,
  input  logic [ENV_W-1:0]   i_env_period,
  input  logic [LEN_W-1:0]   i_length,
  input  logic               i_tick,
  output logic [OUT_W-1:0]   o_output,
  output logic               o_frame_pulse,
  output logic               o_active
);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] delta_reg;
  logic               prev_msb;
  logic [VOL_W-1:0]   level;
  logic               expire;
  logic               wave_high;

  pulse_env_unit #(
    .VOL_W(VOL_W),
    .LEN_W(LEN_W),
    .ENV_W(ENV_W)
  ) u_env (
    .clk    (i_clk),
    .reset  (i_reset),
    .trigger(i_trigger),
    .tick   (i_tick),
    .active (state != ST_IDLE),
    .decay  (state == ST_DECAY),
    .volume (i_volume),
    .length (i_length),
    .period (i_env_period),
    .level  (level),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    if (i_trigger) begin
      if (i_volume == '0)   state_next = ST_IDLE;
      else if (i_env_decay) state_next = ST_DECAY;
      else                  state_next = ST_HOLD;
    end else if (expire) begin
      state_next = ST_IDLE;
    end
  end

  assign wave_high = phase[PHASE_W-1 -: 3] < duty_threshold(i_duty);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_active      <= 1'b0;
      phase         <= '0;
      delta_reg     <= '0;
      prev_msb      <= 1'b0;
      o_frame_pulse <= 1'b0;
      o_output      <= '0;
    end else begin
      state         <= state_next;
      o_active      <= (state_next != ST_IDLE);
      phase         <= i_trigger ? '0 : phase + delta_reg;
      if (i_phase_delta_valid) delta_reg <= i_phase_delta;
      prev_msb      <= phase[PHASE_W-1];
      o_frame_pulse <= phase[PHASE_W-1] && !prev_msb;
      o_output      <= (state != ST_IDLE && wave_high) ? OUT_W'(level) : '0;
    end
  end

endmodule

// File: tb/tb_pulse_channel_gen.sv
// Scoreboard bench: driver predicts each cycle's outputs from a note-level model, monitor compares.
module tb_pulse_channel_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] phase_delta = '0;
  logic        phase_delta_valid = 1'b0;
  logic        trigger = 1'b0;
  logic [1:0]  duty = 2'd2;
  logic [3:0]  volume = '0;
  logic        env_decay = 1'b0;
  logic [3:0]  env_period = '0;
  logic [7:0]  length = '0;
  logic        tick = 1'b0;
  logic [8:0]  out_sample;
  logic        frame_pulse;
  logic        active;

  always #5 clk = ~clk;

  pulse_channel_gen #(.PHASE_W(32), .OUT_W(9), .VOL_W(4), .LEN_W(8), .ENV_W(4)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_phase_delta      (phase_delta),
    .i_phase_delta_valid(phase_delta_valid),
    .i_trigger          (trigger),
    .i_duty             (duty),
    .i_volume           (volume),
    .i_env_decay        (env_decay),
    .i_env_period       (env_period),
    .i_length           (length),
    .i_tick             (tick),
    .o_output           (out_sample),
    .o_frame_pulse      (frame_pulse),
    .o_active           (active)
  );

  typedef struct {
    logic [8:0] out;
    logic       fp;
    logic       act;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Note-level reference: whether a note sounds, its level, ticks left, ticks to next decay step.
  bit [31:0] m_phase, m_delta;
  bit        m_prev_msb, m_on, m_decay;
  int        m_level, m_len_left, m_wait, m_period;

  function automatic bit is_high(bit [31:0] ph, logic [1:0] d);
    int eighth = int'(ph / 32'h2000_0000);
    int lim [4] = '{1, 2, 4, 6};
    return eighth < lim[d];
  endfunction

  task automatic cyc();
    exp_t e;
    if (reset) begin
      e = '{out: 9'd0, fp: 1'b0, act: 1'b0};
      m_phase = 0; m_delta = 0; m_prev_msb = 0; m_on = 0; m_decay = 0;
      m_level = 0; m_len_left = 0; m_wait = 0; m_period = 0;
    end else begin
      bit done;
      e.out = (m_on && is_high(m_phase, duty)) ? 9'(m_level) : 9'd0;
      e.fp  = m_phase[31] && !m_prev_msb;
      m_prev_msb = m_phase[31];
      if (trigger) begin
        m_phase = 0;
        m_on = (volume != 0);
        m_level = int'(volume);
        m_len_left = int'(length);
        m_decay = env_decay;
        m_period = int'(env_period);
        m_wait = m_period;
      end else begin
        m_phase = m_phase + m_delta;
        if (tick && m_on) begin
          done = 0;
          if (m_len_left > 0) begin
            m_len_left--;
            if (m_len_left == 0) done = 1;
          end
          if (m_decay) begin
            if (m_wait == 0) begin
              m_wait = m_period;
              m_level--;
              if (m_level == 0) done = 1;
            end else m_wait--;
          end
          if (done) m_on = 0;
        end
      end
      if (phase_delta_valid) m_delta = phase_delta;
      e.act = m_on;
    end
    q.push_back(e);
    @(negedge clk);
    trigger = 0;
    phase_delta_valid = 0;
    tick = 0;
  endtask

  task automatic trig(input int vol, input bit dec, input int per, input int len, input bit tk);
    volume = 4'(vol); env_decay = dec; env_period = 4'(per); length = 8'(len);
    trigger = 1; tick = tk;
    cyc();
  endtask

  task automatic run(input int n, input int tick_every);
    for (int i = 0; i < n; i++) begin
      tick = (tick_every != 0) && (i % tick_every == tick_every - 1);
      cyc();
    end
  endtask

  task automatic load_delta(input bit [31:0] d);
    phase_delta = d; phase_delta_valid = 1;
    cyc();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (out_sample !== e.out) begin
          errors++;
          $display("FAIL output t=%0t got %0d expected %0d", $time, out_sample, e.out);
        end
        checks++;
        if (frame_pulse !== e.fp) begin
          errors++;
          $display("FAIL frame_pulse t=%0t got %0b expected %0b", $time, frame_pulse, e.fp);
        end
        checks++;
        if (active !== e.act) begin
          errors++;
          $display("FAIL active t=%0t got %0b expected %0b", $time, active, e.act);
        end
      end
    end
  end

  initial begin
    reset = 1;
    run(3, 0);
    reset = 0;
    run(2, 0);

    load_delta(32'h1000_0000);
    duty = 2'd2;
    trig(15, 0, 0, 0, 0);
    run(40, 0);
    duty = 2'd0;
    run(32, 0);
    duty = 2'd3;
    run(32, 0);

    trig(3, 1, 1, 0, 0);
    run(80, 10);

    duty = 2'd2;
    trig(8, 0, 0, 3, 0);
    run(40, 10);
    trig(8, 0, 0, 3, 0);
    run(15, 10);
    trig(8, 0, 0, 3, 1);
    run(40, 10);

    trig(12, 0, 0, 0, 0);
    run(13, 0);
    trig(5, 0, 0, 0, 0);
    run(20, 0);
    trig(0, 0, 0, 0, 0);
    run(20, 0);

    trig(10, 1, 2, 0, 0);
    run(30, 4);
    reset = 1;
    cyc();
    reset = 0;
    run(25, 3);

    load_delta(32'h0800_0000);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) duty = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) begin
        case ($urandom_range(0, 3))
          0: phase_delta = 32'h1000_0000;
          1: phase_delta = 32'h0400_0000;
          2: phase_delta = $urandom;
          default: phase_delta = $urandom >> 3;
        endcase
        phase_delta_valid = 1;
      end
      if ($urandom_range(0, 39) == 0) begin
        volume = 4'($urandom_range(0, 15));
        env_decay = 1'($urandom_range(0, 1));
        env_period = 4'($urandom_range(0, 3));
        length = 8'($urandom_range(0, 7));
        trigger = 1;
      end
      tick = ($urandom_range(0, 4) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc();
      reset = 0;
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_channel_gen.md
Name: pulse_channel_gen

Overview:
Parametrised pulse-wave audio channel: internal phase accumulator, selectable duty cycle, volume, decay envelope and length counter, all under a trigger/tick control FSM. Feeds the PWM output mixer in place of a fixed-duty, fixed-level channel. Driven by the note sequencer (phase delta, trigger) and a frame tick. Reports whether a note is sounding.

Parameters:
PHASE_W, 32, phase accumulator / phase delta width
OUT_W, 9, output sample width (must be >= VOL_W)
VOL_W, 4, volume / envelope level width
LEN_W, 8, note length counter width (in ticks)
ENV_W, 4, envelope period width (in ticks)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_phase_delta  in  PHASE_W  per-cycle phase increment
i_phase_delta_valid  in  1  load i_phase_delta into delta register
i_trigger  in  1  start/restart note (one-cycle strobe)
i_duty  in  2  duty select: 0=12.5%, 1=25%, 2=50%, 3=75%
i_volume  in  VOL_W  initial level, sampled on trigger
i_env_decay  in  1  sampled on trigger: 1=decaying envelope, 0=constant level
i_env_period  in  ENV_W  sampled on trigger: decay step every (period+1) ticks
i_length  in  LEN_W  sampled on trigger: note length in ticks, 0=infinite
i_tick  in  1  frame tick strobe for envelope/length clocking
o_output  out  OUT_W  sample, registered
o_frame_pulse  out  1  one-cycle pulse on phase MSB rising edge, registered
o_active  out  1  high when FSM not IDLE

Behaviour:
- Reset: state=IDLE, phase=0, delta_reg=0, level=0, length counter=0, env divider=0, o_output=0, o_frame_pulse=0, o_active=0.
- delta_reg <= i_phase_delta when valid; new delta used from the following cycle.
- phase <= phase + delta_reg every cycle, wraps mod 2^PHASE_W; on trigger phase <= 0 (trigger wins over accumulate).
- Duty: t = phase[PHASE_W-1 -: 3]; high when t < {1,2,4,6}[i_duty]. i_duty is live, not sampled.
- o_output <= (state!=IDLE && high) ? zero-extended level : 0. One-cycle latency from phase/state/level.
- o_frame_pulse <= phase MSB==1 && previous MSB==0 (previous-MSB register resets to 0).
- FSM states IDLE, HOLD, DECAY:
  - any state + trigger: level<=i_volume, len<=i_length, div<=i_env_period; go HOLD if i_env_decay=0, else DECAY; if i_volume==0 go IDLE.
  - HOLD/DECAY + tick (no trigger): if len!=0 then len<=len-1; len==1 on this tick -> IDLE. len==0 never expires.
  - DECAY + tick: div==0 -> div<=period, level<=level-1; level reaching 0 -> IDLE. Else div<=div-1.
  - Length expiry and level-zero on the same tick -> IDLE (single transition).
  - trigger and tick in same cycle: tick ignored.
- o_active = (state != IDLE), registered alongside state.
- Reset mid-note: immediate return to reset values next cycle, regardless of trigger/tick.

Decomposition:
- pulse_channel_pkg: state enum (IDLE/HOLD/DECAY), duty code constants, duty threshold table.
- Sub-module pulse_env_unit: level register, envelope divider, length counter; outputs level and expire strobe to the FSM.

Test Plan:
- Reset then delta=2^28 valid, trigger vol=15, duty=2, len=0, decay=0 -> o_output=15 for 8 cycles, 0 for 8 cycles, repeating; first 15 two cycles after trigger.
- Same delta, duty=0 -> 2 cycles of 15 then 14 of 0 per 16-cycle period; duty=3 -> 12 high/4 low; o_frame_pulse once per 16 cycles, 1 cycle wide.
- Trigger vol=3, decay=1, period=1, len=0, tick every 10 cycles -> level 3,2,1 stepping every 2nd tick; IDLE and o_active=0 on 6th tick; o_output=0 after.
- Trigger vol=8, decay=0, len=3 -> o_active falls on 3rd tick; trigger+tick same cycle -> len reloads, no decrement.
- Retrigger mid-note with vol=5 -> phase restarts at 0, output high level 5 two cycles later; trigger vol=0 -> stays IDLE, output 0.
- Assert i_reset during DECAY -> next cycle all outputs 0, state IDLE; deassert, no trigger -> outputs stay 0.
